// File: rtl/deglitch_ctrl.sv
// deglitch_ctrl: prescaled integrating deglitch filters feeding a round-robin event queue.
// Optional event timestamping is enabled by defining DEGLITCH_CTRL_TS_EN.
module deglitch_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 4,
    parameter int PRESC_W = 8
`ifdef DEGLITCH_CTRL_TS_EN
    ,
    parameter int TS_W    = 16
`endif
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         clr_i,
    input  logic                                         en_i,
    input  logic [PRESC_W-1:0]                           prescale_i,
    input  logic [CNT_W-1:0]                             threshold_i,
    input  logic [NUM_CH-1:0]                            d_i,
    output logic [NUM_CH-1:0]                            q_o,
    output logic                                         evt_valid_o,
    input  logic                                         evt_ready_i,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] evt_ch_o,
    output logic                                         evt_level_o,
    output logic                                         overrun_o
`ifdef DEGLITCH_CTRL_TS_EN
    ,
    output logic [TS_W-1:0]                              evt_ts_o
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, PRESENT} state_e;

    logic               flush;
    logic               tick;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   thr;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  filt_q, filt_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [NUM_CH-1:0]  plevel_q, plevel_d;
    logic [NUM_CH-1:0]  grant;
    logic               grantAny;
    logic               overrun_q, overrun_d;
    logic [CH_W-1:0]    rrPtr_q, rrPtr_d;
    logic [CH_W-1:0]    pickCh;
    logic               pickFound;
    logic [CH_W-1:0]    evtCh_q;
    logic               evtLevel_q;
    state_e             state_q, state_d;

    assign flush = rst_i | clr_i;
    assign tick  = en_i && (pcnt_q == prescale_i);
    assign thr   = (threshold_i == '0) ? CNT_W'(1) : threshold_i;

    always_comb begin
        pcnt_d = pcnt_q;
        if (en_i) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
        end
    end

    // A counter above a freshly lowered threshold is pulled back to it before integrating again.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick) begin
                if (cnt_q[i] > thr) begin
                    cnt_d[i] = thr;
                end else if (d_i[i] && (cnt_q[i] < thr)) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else if (!d_i[i] && (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
                if (cnt_d[i] == thr) begin
                    filt_d[i] = 1'b1;
                end else if (cnt_d[i] == '0) begin
                    filt_d[i] = 1'b0;
                end
            end
        end
    end

    // A change landing on a slot that is being granted this cycle re-arms it without overrun.
    always_comb begin
        pending_d = pending_q & ~grant;
        plevel_d  = plevel_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (filt_d[i] != filt_q[i]) begin
                pending_d[i] = 1'b1;
                plevel_d[i]  = filt_d[i];
                if (pending_q[i] && !grant[i]) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // First pass searches from rrPtr upward, second pass wraps around from channel 0.
    always_comb begin
        pickFound = 1'b0;
        pickCh    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pickFound && pending_q[i] && (CH_W'(i) >= rrPtr_q)) begin
                pickFound = 1'b1;
                pickCh    = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pickFound && pending_q[i]) begin
                pickFound = 1'b1;
                pickCh    = CH_W'(i);
            end
        end
    end

    assign grantAny = (state_q == IDLE) && pickFound;

    always_comb begin
        grant   = '0;
        rrPtr_d = rrPtr_q;
        if (grantAny) begin
            grant[pickCh] = 1'b1;
            rrPtr_d = (pickCh == CH_W'(NUM_CH - 1)) ? '0 : pickCh + CH_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pickFound)   state_d = PRESENT;
            PRESENT: if (evt_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        evt_valid_o = (state_q == PRESENT);
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            pcnt_q     <= '0;
            cnt_q      <= '{default: '0};
            filt_q     <= '0;
            pending_q  <= '0;
            plevel_q   <= '0;
            overrun_q  <= 1'b0;
            rrPtr_q    <= '0;
            evtCh_q    <= '0;
            evtLevel_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            filt_q    <= filt_d;
            pending_q <= pending_d;
            plevel_q  <= plevel_d;
            overrun_q <= overrun_d;
            rrPtr_q   <= rrPtr_d;
            if (grantAny) begin
                evtCh_q    <= pickCh;
                evtLevel_q <= plevel_q[pickCh];
            end
        end
    end

    assign q_o         = filt_q;
    assign evt_ch_o    = evtCh_q;
    assign evt_level_o = evtLevel_q;
    assign overrun_o   = overrun_q;

`ifdef DEGLITCH_CTRL_TS_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] pendTs_q [NUM_CH];
    logic [TS_W-1:0] evtTs_q;

    // Slots capture the tick count as it stood before this tick's increment.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            ts_q     <= '0;
            pendTs_q <= '{default: '0};
            evtTs_q  <= '0;
        end else begin
            if (tick) begin
                ts_q <= ts_q + TS_W'(1);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (filt_d[i] != filt_q[i]) begin
                    pendTs_q[i] <= ts_q;
                end
            end
            if (grantAny) begin
                evtTs_q <= pendTs_q[pickCh];
            end
        end
    end

    assign evt_ts_o = evtTs_q;
`endif

endmodule
